sum_frame_tx: RTL and testbench
===============================

# sum_frame_tx

Downstream stage of the nibble adder. Accepts the registered 4-bit sums it produces through a valid/ready handshake and accumulates a fixed number of them into an 8-bit saturating total. It then transmits that total on a single pin as an 8N1 serial frame at clk/CLKS_PER_BIT, so a host can read adder results on one output.

## Interface
- NSAMP, 4: sums accumulated per frame; legal 1..32
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal 2..255
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- sum_in  in  4  unsigned sum from the adder stage
- sum_valid  in  1  sum_in holds a new sum
- sum_ready  out  1  block accepts sum_in this cycle
- tx  out  1  serial line, idle high
- busy  out  1  a frame is being transmitted
- sat  out  1  current/last frame total clipped at 255
- frame_cnt  out  4  frames completed, wraps 15 -> 0

## Operation
- States: ACCUM, START, DATA, STOP.
- Reset values (next edge with reset=1): state=ACCUM, acc=0, sample count=0, bit count=0, baud counter=0, tx=1, busy=0, sat=0, frame_cnt=0, sum_ready=1.
- ACCUM: sum_ready=1. Accept on any edge where sum_valid and sum_ready are both 1.
  - acc <= min(acc + sum_in, 255), computed at 9 bits.
  - sat <= 1 if the 9-bit result > 255 (sticky within frame).
  - On accepting sample NSAMP, latch the final acc into the shift register, go to START, sum_ready <= 0, busy <= 1.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits of the latched total, LSB first, each held CLKS_PER_BIT cycles. Then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end:
  - frame_cnt += 1, mod 16.
  - acc, sample count and sat cleared.
  - busy <= 0, sum_ready <= 1, return to ACCUM.
- sum_valid while sum_ready=0: ignored, no data lost on the block side. The upstream must hold sum_valid/sum_in until accepted.
- sum_valid=0 in ACCUM: no state change.
- sat is readable through the whole frame. It clears only when the next ACCUM begins.
- Reset mid-frame: the partial frame is discarded. tx returns to 1 at that edge, and all state takes reset values.
- NSAMP=1: every accepted sum immediately launches a frame.

## Timing
- tx, busy, sum_ready, sat, frame_cnt are all registered; there is no combinational input-to-output path.
- Edge E accepts the last sample. At E+1, tx=0, busy=1, sum_ready=0.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the tx falling edge to the first cycle with sum_ready=1 again.
- At edge E+10*CLKS_PER_BIT:
  - sum_ready returns to 1.
  - A sample presented in that cycle is accepted at edge E+10*CLKS_PER_BIT+1.
- Max throughput: NSAMP + 10*CLKS_PER_BIT cycles per frame.
- Baud counter runs 0..CLKS_PER_BIT-1. It advances only in START/DATA/STOP and resets to 0 on each bit boundary.

## Test plan
- Basic frame, defaults (NSAMP=4, CLKS_PER_BIT=4):
  - Stimulus: sums 3,5,7,1 on consecutive cycles with valid=1.
  - Response: total 0x10. tx low 4 cycles starting the cycle after the 4th accept, then bits 0,0,0,0,1,0,0,0 at 4 cycles each, then high 4 cycles (40 cycles total). Then frame_cnt=1, sat=0, sum_ready=1.
- Saturation, NSAMP=20:
  - Stimulus: twenty sums of 15.
  - Response: acc clips at 255, sat=1 from the 18th accept onward, frame data bits all 1. After stop, sat=0.
- Backpressure:
  - Stimulus: hold sum_valid=1, sum_in=9 throughout the frame from the basic test.
  - Response: no accept while busy=1. The first accept lands on the first edge with sum_ready=1. The next frame's acc starts at 9.
- Idle gaps:
  - Stimulus: 4 sums of 2 separated by 3-cycle sum_valid=0 gaps.
  - Response: total 0x08 transmitted. Frame timing is unchanged relative to the last accept.
- Reset mid-frame:
  - Stimulus: assert reset for 1 cycle during DATA bit 3.
  - Response: at that edge tx=1, busy=0, sum_ready=1, frame_cnt unchanged from its reset value 0. The next 4 sums of 1 produce a clean frame with data 0x04.
- Wrap:
  - Stimulus: 16 complete frames.
  - Response: frame_cnt reads 0 after the 16th stop bit.

Source files
------------

// File: rtl/sum_frame_tx.sv
// Accumulates NSAMP adder sums into a saturating 8-bit total, then sends the
// total LSB first as an 8N1 frame on tx at clk/CLKS_PER_BIT.
module sum_frame_tx #(
    parameter int NSAMP        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sum_in,
    input  logic       sum_valid,
    output logic       sum_ready,
    output logic       tx,
    output logic       busy,
    output logic       sat,
    output logic [3:0] frame_cnt
);

    localparam int CNT_W = $clog2(NSAMP + 1);
    localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'(NSAMP - 1);
    localparam logic [7:0]       BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {ACCUM, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       baud_q, baud_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             sat_q, sat_d;
    logic [3:0]       frame_q, frame_d;
    logic             ready_q, ready_d;

    logic [8:0]       sum9;
    logic             baud_end;

    function automatic logic [7:0] sat_add(input logic [8:0] s);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign sum9     = {1'b0, acc_q} + {5'b0, sum_in};
    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        sat_d   = sat_q;
        frame_d = frame_q;
        ready_d = ready_q;
        case (state_q)
            ACCUM: begin
                if (sum_valid && ready_q) begin
                    acc_d = sat_add(sum9);
                    sat_d = sat_q | sum9[8];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_SAMP) begin
                        shreg_d = sat_add(sum9);
                        state_d = START;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                        tx_d    = 1'b0;
                        baud_d  = 8'd0;
                    end
                end
            end
            START: begin
                baud_d = baud_q + 8'd1;
                if (baud_end) begin
                    baud_d  = 8'd0;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + 8'd1;
                if (baud_end) begin
                    baud_d = 8'd0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Shift so the next bit to send is always at shreg_q[0].
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end
            end
            STOP: begin
                baud_d = baud_q + 8'd1;
                if (baud_end) begin
                    baud_d  = 8'd0;
                    frame_d = frame_q + 4'd1;
                    acc_d   = 8'd0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= 8'd0;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            baud_q  <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            sat_q   <= 1'b0;
            frame_q <= 4'd0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            sat_q   <= sat_d;
            frame_q <= frame_d;
            ready_q <= ready_d;
        end
    end

    // The shift register is pure data and is always reloaded before use.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign sum_ready = ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign sat       = sat_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_sum_frame_tx.sv
// Scoreboard bench for sum_frame_tx: a frame-level reference model predicts the
// outputs each cycle, a monitor compares them against two differently sized DUTs.
module tb_sum_frame_tx;

    localparam int NS0 = 4;
    localparam int C0  = 4;
    localparam int NS1 = 20;
    localparam int C1  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0][3:0] sin;
    logic [1:0]      vld;
    logic [1:0]      rdy, txw, bsy, satw;
    logic [1:0][3:0] fcw;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sum_frame_tx #(.NSAMP(NS0), .CLKS_PER_BIT(C0)) dut0 (
        .clk(clk), .reset(reset), .sum_in(sin[0]), .sum_valid(vld[0]),
        .sum_ready(rdy[0]), .tx(txw[0]), .busy(bsy[0]), .sat(satw[0]),
        .frame_cnt(fcw[0])
    );

    sum_frame_tx #(.NSAMP(NS1), .CLKS_PER_BIT(C1)) dut1 (
        .clk(clk), .reset(reset), .sum_in(sin[1]), .sum_valid(vld[1]),
        .sum_ready(rdy[1]), .tx(txw[1]), .busy(bsy[1]), .sat(satw[1]),
        .frame_cnt(fcw[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a frame is a 10-bit word {stop, total, start} played out
    // one bit per CLKS_PER_BIT cycles; t is the elapsed cycle count, -1 when idle.
    int          m_acc [2];
    int          m_n   [2];
    int          m_t   [2];
    int          m_fc  [2];
    bit          m_sat [2];
    logic [9:0]  m_bits[2];
    logic [7:0]  expq0[$];
    logic [7:0]  expq1[$];

    task automatic model_step(input int k, output logic [7:0] e);
        int ns, c, s;
        ns = (k == 0) ? NS0 : NS1;
        c  = (k == 0) ? C0 : C1;
        if (reset) begin
            m_acc[k] = 0; m_n[k] = 0; m_t[k] = -1; m_fc[k] = 0; m_sat[k] = 0;
        end else if (m_t[k] >= 0) begin
            m_t[k]++;
            if (m_t[k] == 10 * c) begin
                m_t[k]   = -1;
                m_fc[k]  = (m_fc[k] + 1) % 16;
                m_acc[k] = 0;
                m_n[k]   = 0;
                m_sat[k] = 0;
            end
        end else if (vld[k]) begin
            s = m_acc[k] + int'(sin[k]);
            if (s > 255) begin
                m_sat[k] = 1;
                m_acc[k] = 255;
            end else begin
                m_acc[k] = s;
            end
            m_n[k]++;
            if (m_n[k] == ns) begin
                m_bits[k] = {1'b1, 8'(m_acc[k]), 1'b0};
                m_t[k]    = 0;
            end
        end
        e = {(m_t[k] < 0) ? 1'b1 : m_bits[k][m_t[k] / c],
             m_t[k] >= 0, m_t[k] < 0, m_sat[k], 4'(m_fc[k])};
    endtask

    always @(posedge clk) begin
        logic [7:0] e;
        model_step(0, e);
        expq0.push_back(e);
        model_step(1, e);
        expq1.push_back(e);
    end

    // Monitor: outputs packed as {tx, busy, sum_ready, sat, frame_cnt[3:0]}.
    always @(negedge clk) begin
        logic [7:0] e, a;
        if (expq0.size() > 0) begin
            e = expq0.pop_front();
            a = {txw[0], bsy[0], rdy[0], satw[0], fcw[0]};
            chk("outs_dut0", int'(a), int'(e));
        end
        if (expq1.size() > 0) begin
            e = expq1.pop_front();
            a = {txw[1], bsy[1], rdy[1], satw[1], fcw[1]};
            chk("outs_dut1", int'(a), int'(e));
        end
    end

    task automatic put(input int k, input logic v, input logic [3:0] s);
        vld[k] = v;
        sin[k] = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] data;
        reset = 1'b1;
        vld   = '0;
        sin   = '0;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Basic frame: 3+5+7+1 = 0x10, decoded from tx at mid-bit
        put(0, 1, 3); put(0, 1, 5); put(0, 1, 7); put(0, 1, 1);
        vld[0] = 1'b0;
        idle(2);
        chk("basic_start", int'(txw[0]), 0);
        data = '0;
        for (int i = 0; i < 8; i++) begin
            idle(C0);
            data[i] = txw[0];
        end
        chk("basic_data", int'(data), 'h10);
        idle(C0);
        chk("basic_stop", int'(txw[0]), 1);
        idle(4);
        chk("basic_fc", int'(fcw[0]), 1);
        chk("basic_rdy", int'(rdy[0]), 1);
        chk("basic_sat", int'(satw[0]), 0);

        // Backpressure: sum 9 held valid through and past the frame
        put(0, 1, 3); put(0, 1, 5); put(0, 1, 7); put(0, 1, 1);
        vld[0] = 1'b1; sin[0] = 4'd9;
        idle(10 * C0 + 6);
        vld[0] = 1'b0;
        idle(10 * C0 + 6);

        // Idle gaps between accepted sums
        for (int i = 0; i < 4; i++) begin
            put(0, 1, 2);
            put(0, 0, 0); put(0, 0, 0); put(0, 0, 0);
        end
        idle(10 * C0 + 4);

        // Reset during data bit 3
        put(0, 1, 8); put(0, 1, 8); put(0, 1, 8); put(0, 1, 8);
        vld[0] = 1'b0;
        idle(17);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("rst_tx", int'(txw[0]), 1);
        chk("rst_busy", int'(bsy[0]), 0);
        chk("rst_rdy", int'(rdy[0]), 1);
        chk("rst_fc", int'(fcw[0]), 0);
        put(0, 1, 1); put(0, 1, 1); put(0, 1, 1); put(0, 1, 1);
        vld[0] = 1'b0;
        idle(10 * C0 + 4);
        chk("rst_next_fc", int'(fcw[0]), 1);

        // Saturation on the 20-sample instance
        for (int i = 0; i < NS1; i++) put(1, 1, 15);
        vld[1] = 1'b0;
        idle(5);
        chk("sat_high", int'(satw[1]), 1);
        idle(10 * C1 + 4);
        chk("sat_clr", int'(satw[1]), 0);
        chk("sat_fc", int'(fcw[1]), 1);

        // Random traffic on both instances
        for (int i = 0; i < 600; i++) begin
            vld[0] = 1'($urandom_range(0, 1));
            sin[0] = 4'($urandom_range(0, 15));
            vld[1] = ($urandom_range(0, 3) != 0);
            sin[1] = 4'($urandom_range(8, 15));
            @(negedge clk);
        end
        vld = '0;
        idle(10 * C0 + 10);

        // Frame counter wrap after 16 frames
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < NS0; i++) put(0, 1, 4'($urandom_range(0, 15)));
            vld[0] = 1'b0;
            idle(10 * C0 + 2);
        end
        chk("wrap_fc", int'(fcw[0]), 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
